// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the icache/dcache RAM arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, IGRANT = 2'd1, DGRANT = 2'd2} arb_state_t;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between icache and dcache, dcache priority
// with an anti-starvation counter that forces an icache win.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  arb_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  logic dreq, done, is_err;
  assign dreq = dREN | dWEN;
  assign done = ramstate_t'(ramstate) == ACCESS || ramstate_t'(ramstate) == ERROR;
  assign is_err = ramstate_t'(ramstate) == ERROR;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    iwait = 1'b1;
    dwait = 1'b1;
    iload = '0;
    dload = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    case (state_q)
      IDLE: begin
        if (iREN && cnt_q >= LIM) begin
          state_d = IGRANT;
          cnt_d = '0;
        end else if (dreq) begin
          state_d = DGRANT;
          cnt_d = !iREN ? '0 : (cnt_q < LIM ? cnt_q + 1'b1 : cnt_q);
        end else if (iREN) begin
          state_d = IGRANT;
          cnt_d = '0;
        end
      end
      IGRANT: begin
        ramREN = 1'b1;
        ramaddr = iaddr;
        if (done) begin
          iwait = 1'b0;
          iload = ramload;
          err_d = err_q | is_err;
          state_d = IDLE;
        end else if (!iREN) state_d = IDLE;
      end
      DGRANT: begin
        ramaddr = daddr;
        ramstore = dstore;
        ramWEN = dWEN;
        ramREN = !dWEN;
        if (done) begin
          dwait = 1'b0;
          dload = ramload;
          err_d = err_q | is_err;
          state_d = IDLE;
        end else if (!dreq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST;
  logic iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0] ramstate;
  logic iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int total = 0;
  int bad = 0;
  mem_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    nRST = 1'b0;
    {iREN, dREN, dWEN} = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
    #3;
    chk("rst_iwait", 32'(iwait), 1);
    chk("rst_dwait", 32'(dwait), 1);
    chk("rst_ramREN", 32'(ramREN), 0);
    chk("rst_ramWEN", 32'(ramWEN), 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_err", 32'(err), 0);
    nRST = 1'b1;
    tick();
    iREN = 1; iaddr = 32'h100; dREN = 1; daddr = 32'h40;
    #1;
    chk("sim_idle_noram", 32'(ramREN), 0);
    tick();
    #1;
    chk("sim_dgrant_addr", ramaddr, 32'h40);
    chk("sim_dgrant_ren", 32'(ramREN), 1);
    chk("sim_dwait_free", 32'(dwait), 1);
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #1;
    chk("sim_dwait_done", 32'(dwait), 0);
    chk("sim_dload", dload, 32'hDEADBEEF);
    chk("sim_iwait_hi", 32'(iwait), 1);
    chk("sim_iload_zero", iload, 0);
    dREN = 0;
    tick();
    ramstate = 2'd0;
    #1;
    chk("sim_bubble_idle", 32'(ramREN), 0);
    tick();
    ramstate = 2'd2; ramload = 32'h11111111;
    #1;
    chk("sim_igrant_addr", ramaddr, 32'h100);
    chk("sim_iwait_done", 32'(iwait), 0);
    chk("sim_iload", iload, 32'h11111111);
    iREN = 0;
    tick();
    iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h80; dstore = 32'hA5A5A5A5;
    ramload = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      chk($sformatf("stv_dgrant%0d_wen", i), 32'(ramWEN), 1);
      chk($sformatf("stv_dgrant%0d_dwait", i), 32'(dwait), 0);
      chk($sformatf("stv_dgrant%0d_iwait", i), 32'(iwait), 1);
      tick();
      #1;
      chk($sformatf("stv_idle%0d_wen", i), 32'(ramWEN), 0);
    end
    tick();
    #1;
    chk("stv_igrant_addr", ramaddr, 32'h200);
    chk("stv_igrant_ren", 32'(ramREN), 1);
    chk("stv_igrant_wen", 32'(ramWEN), 0);
    chk("stv_igrant_store", ramstore, 0);
    chk("stv_igrant_iwait", 32'(iwait), 0);
    chk("stv_igrant_dwait", 32'(dwait), 1);
    tick();
    tick();
    #1;
    chk("stv_cnt_cleared_dgrant", 32'(dwait), 0);
    chk("stv_cnt_cleared_addr", ramaddr, 32'h80);
    iREN = 0; dWEN = 0; ramstate = 2'd0;
    tick();
    dREN = 1; daddr = 32'h44; ramstate = 2'd1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("busy%0d_dwait", i), 32'(dwait), 1);
      chk($sformatf("busy%0d_ren", i), 32'(ramREN), 1);
      tick();
    end
    ramstate = 2'd2; ramload = 32'h33333333;
    #1;
    chk("busy_done_dwait", 32'(dwait), 0);
    chk("busy_done_ren", 32'(ramREN), 1);
    chk("busy_done_dload", dload, 32'h33333333);
    dREN = 0; ramstate = 2'd0;
    tick();
    iREN = 1; iaddr = 32'h300;
    tick();
    ramstate = 2'd3; ramload = 32'h00000BAD;
    #1;
    chk("err_iwait", 32'(iwait), 0);
    chk("err_iload", iload, 32'h00000BAD);
    chk("err_not_yet", 32'(err), 0);
    iREN = 0;
    tick();
    ramstate = 2'd0;
    #1;
    chk("err_set", 32'(err), 1);
    dREN = 1; daddr = 32'h48;
    tick();
    ramstate = 2'd2;
    #1;
    chk("err_ok_dwait", 32'(dwait), 0);
    dREN = 0;
    tick();
    ramstate = 2'd0;
    #1;
    chk("err_sticky", 32'(err), 1);
    dREN = 1; daddr = 32'h50; ramstate = 2'd1;
    tick();
    #1;
    chk("abt_dwait", 32'(dwait), 1);
    dREN = 0; iREN = 1; iaddr = 32'h400;
    #1;
    chk("abt_drop_dwait", 32'(dwait), 1);
    chk("abt_drop_ren", 32'(ramREN), 1);
    tick();
    ramstate = 2'd0;
    #1;
    chk("abt_idle_ren", 32'(ramREN), 0);
    chk("abt_idle_dwait", 32'(dwait), 1);
    tick();
    ramstate = 2'd2; ramload = 32'h44444444;
    #1;
    chk("abt_next_iaddr", ramaddr, 32'h400);
    chk("abt_next_iwait", 32'(iwait), 0);
    iREN = 0;
    tick();
    dWEN = 1; daddr = 32'h60; dstore = 32'h55; ramstate = 2'd1;
    tick();
    #1;
    chk("mid_wen", 32'(ramWEN), 1);
    nRST = 0;
    #1;
    chk("mid_rst_wen", 32'(ramWEN), 0);
    chk("mid_rst_dwait", 32'(dwait), 1);
    chk("mid_rst_err", 32'(err), 0);
    dWEN = 0;
    tick();
    nRST = 1;
    #1;
    chk("mid_post_ren", 32'(ramREN), 0);
    chk("mid_post_wen", 32'(ramWEN), 0);
    chk("mid_post_addr", ramaddr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single-ported RAM between the icache miss path and the dcache miss/writeback path.
- Sits below the cache wrapper. It takes the flat request signals that the caches drive toward cache control, and drives one RAM port.
- Registered grant FSM with dcache priority and an anti-starvation counter for the icache.
- Completion is signalled back through per-requester wait and load lines.

Parameters:
WORD_W, 32, data and address width in bits
STARVE_LIMIT, 4, number of consecutive dcache grants, with iREN pending, before the icache is forced to win
CNT_W, 3, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
iREN  in  1  icache read request
iaddr  in  WORD_W  icache word address
iwait  out  1  high until the icache access completes
iload  out  WORD_W  icache read data; valid when iwait is low
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  WORD_W  dcache word address
dstore  in  WORD_W  dcache write data
dwait  out  1  high until the dcache access completes
dload  out  WORD_W  dcache read data; valid when dwait is low
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  out  1  sticky flag: a RAM ERROR has been seen since reset

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low. All state resets on the falling edge of nRST:
  - state=IDLE, starve_cnt=0, err=0.
  - Combinational outputs in reset: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- FSM states: IDLE, IGRANT, DGRANT. The grant is registered; the RAM is never driven in IDLE.
- IDLE arbitration, evaluated each cycle:
  - dreq = dREN|dWEN.
  - If iREN and starve_cnt>=STARVE_LIMIT, go to IGRANT.
  - Else if dreq, go to DGRANT.
  - Else if iREN, go to IGRANT.
  - Else stay in IDLE.
- DGRANT outputs:
  - ramaddr=daddr, ramstore=dstore.
  - dWEN high: ramWEN=1, ramREN=0; a write takes precedence if dREN and dWEN are both high.
  - Otherwise: ramREN=1.
- IGRANT outputs: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion: in a grant state, when ramstate is ACCESS or ERROR:
  - The granted requester's wait goes low combinationally in that same cycle.
  - The granted load is driven with ramload.
  - The FSM returns to IDLE on the next edge.
  - ERROR also sets err; it stays set until reset.
- Wait: while ramstate is FREE or BUSY, hold the grant. The granted wait stays high.
- Abort: if the granted requester drops its request while in a grant state, with no completion that cycle:
  - Its wait stays high and the RAM enables stay asserted for that cycle.
  - The FSM returns to IDLE on the next edge with no completion.
- Non-granted requester: its wait is always high and its load is 0.
- Latency:
  - Request seen in IDLE at cycle n; RAM driven from cycle n+1.
  - Minimum completion is cycle n+1, when ramstate=ACCESS immediately.
  - Back-to-back accesses by the same requester have one IDLE bubble.
- starve_cnt, updated on the transition into DGRANT:
  - If iREN is high, increment, saturating at STARVE_LIMIT.
  - If iREN is low, clear to 0.
- starve_cnt is also cleared on the transition into IGRANT.
- Address and data are passed through, not latched: requesters must hold them stable while their wait is high.

Decomposition:
- Shared package mem_arb_pkg:
  - ramstate_t enum: FREE, BUSY, ACCESS, ERROR.
  - arb_state_t enum: IDLE, IGRANT, DGRANT.
  - word_t typedef.
- One module, no sub-module needed. The starvation counter is an inline always_ff.

Test Plan:
- Reset mid-transfer: assert nRST=0 while in DGRANT with ramWEN=1 -> immediately ramWEN=0, dwait=1, err=0; after release the state is IDLE.
- Simultaneous request: iREN=1, dREN=1, daddr=0x40, RAM answers ACCESS with ramload=0xDEADBEEF -> DGRANT first; dwait low for one cycle with dload=0xDEADBEEF; iwait stays high; the icache is granted on the next arbitration.
- Starvation: iREN held, dWEN reasserted after every completion -> exactly 4 dcache grants, then an IGRANT with ramaddr=iaddr; starve_cnt=0 afterward.
- BUSY wait: dREN with ramstate=BUSY for 3 cycles, then ACCESS -> dwait high for 3 cycles, low on the 4th; ramREN held 4 cycles.
- Error: the icache access sees ramstate=ERROR -> iwait low for that cycle, err=1 and sticky through later successful accesses.
- Abort: DGRANT with BUSY, dREN dropped -> IDLE next cycle, dwait never low, next iREN granted normally.
